// File: rtl/frame_capture_pkg.sv
// Shared types and defaults for the frame capture buffer: FSM encoding,
// default geometry and statistics counter widths.
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_FRAME_WORDS = 1024;

  localparam int FRAME_CNT_W  = 16;
  localparam int DROP_CNT_W   = 8;
  localparam int RESYNC_CNT_W = 8;

endpackage

// File: rtl/fcb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Written so synthesis maps the array onto block RAM.
module fcb_sdp_ram
  import frame_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array has no reset; resetting it would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// Captures one streamed frame into RAM, pulses eof when it is complete and
// holds it for the classifier until frame_done releases the buffer.
module frame_capture_buffer
  import frame_capture_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_sof,
  input  logic                    frame_done,
  output logic                    eof,
  input  logic                    ram_rd_en,
  input  logic [ADDR_W-1:0]       ram_rd_addr,
  output logic [DATA_W-1:0]       ram_rd_data,
  output logic [FRAME_CNT_W-1:0]  frame_count,
  output logic [DROP_CNT_W-1:0]   drop_count,
  output logic [RESYNC_CNT_W-1:0] resync_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic              ram_wr_en;
  logic              accept;
  logic              complete, drop, resync;

  assign in_ready = (state_q != FULL);
  assign accept   = in_valid & in_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    ram_wr_en   = 1'b0;
    ram_wr_addr = wr_addr_q;
    complete    = 1'b0;
    drop        = 1'b0;
    resync      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = '0;
            wr_addr_d   = ADDR_W'(1);
            state_d     = FILL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          ram_wr_en = 1'b1;
          // A sof always wins, even on the last word of a frame.
          if (in_sof) begin
            ram_wr_addr = '0;
            wr_addr_d   = ADDR_W'(1);
            resync      = 1'b1;
          end else if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = FULL;
            complete  = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      FULL: begin
        if (frame_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      eof          <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
      resync_count <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      eof       <= complete;
      if (complete) frame_count <= frame_count + FRAME_CNT_W'(1);
      if (drop && (drop_count != '1)) drop_count <= drop_count + DROP_CNT_W'(1);
      if (resync && (resync_count != '1)) resync_count <= resync_count + RESYNC_CNT_W'(1);
    end
  end

  fcb_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Scoreboard bench for frame_capture_buffer: a frame-level reference model
// predicts eof events and read data; monitors compare when the DUT presents them.
module tb_frame_capture_buffer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FW = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          frame_done = 1'b0;
  logic          eof;
  logic          ram_rd_en = 1'b0;
  logic [AW-1:0] ram_rd_addr = '0;
  logic [DW-1:0] ram_rd_data;
  logic [15:0]   frame_count;
  logic [7:0]    drop_count;
  logic [7:0]    resync_count;

  frame_capture_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .frame_done   (frame_done),
    .eof          (eof),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .frame_count  (frame_count),
    .drop_count   (drop_count),
    .resync_count (resync_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct {
    int unsigned cyc;
    logic [15:0] fc;
  } eof_exp_t;

  logic [DW-1:0] m_mem [0:FW-1];
  logic [DW-1:0] m_frame[$];
  bit            m_collect = 0;
  bit            m_full = 0;
  int            m_fc = 0, m_drop = 0, m_resync = 0;
  eof_exp_t      eof_q[$];
  logic [DW-1:0] rd_q[$];
  int unsigned   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_accept(input bit sof, input logic [DW-1:0] d);
    if (sof) begin
      if (m_collect && m_resync < 255) m_resync++;
      m_collect = 1;
      m_frame.delete();
      m_frame.push_back(d);
      m_mem[0] = d;
    end else if (!m_collect) begin
      if (m_drop < 255) m_drop++;
    end else begin
      m_frame.push_back(d);
      m_mem[m_frame.size()-1] = d;
      if (m_frame.size() == FW) begin
        m_full    = 1;
        m_collect = 0;
        m_fc      = (m_fc + 1) % 65536;
        eof_q.push_back('{cyc + 1, 16'(m_fc)});
      end
    end
  endtask

  // One clock cycle of stimulus; the model advances by the edge that follows.
  task automatic drive(input bit v, input bit sof, input logic [DW-1:0] d,
                       input bit done, input bit rd, input logic [AW-1:0] ra);
    bit was_full;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_data = d; frame_done = done;
    ram_rd_en = rd; ram_rd_addr = ra;
    #1;
    check("in_ready", in_ready, !m_full);
    was_full = m_full;
    if (rd) rd_q.push_back(m_mem[ra]);
    if (v && !was_full) model_accept(sof, d);
    if (done && was_full) m_full = 0;
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] base, input bit with_sof);
    for (int i = 0; i < n; i++)
      drive(1'b1, with_sof && (i == 0), base + DW'(i), 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
  endtask

  task automatic release_buf();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_count"},  frame_count,  m_fc);
    check({tag, "_drop_count"},   drop_count,   m_drop);
    check({tag, "_resync_count"}, resync_count, m_resync);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #3;
    in_valid = 0; in_sof = 0; frame_done = 0; ram_rd_en = 0;
    reset = 1'b1;
    #1;
    m_collect = 0; m_full = 0; m_frame.delete();
    m_fc = 0; m_drop = 0; m_resync = 0;
    rd_q.delete(); eof_q.delete();
    check("rst_in_ready", in_ready, 1);
    check("rst_eof", eof, 0);
    check("rst_rd_data", ram_rd_data, 0);
    check_counters("rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitors ----------------
  logic          rd_fire;
  logic [DW-1:0] rd_exp;
  eof_exp_t      eof_exp;

  always @(posedge clk or posedge reset)
    if (reset) rd_fire <= 1'b0;
    else       rd_fire <= ram_rd_en;

  always @(negedge clk) begin
    if (!reset && rd_fire) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        rd_exp = rd_q.pop_front();
        check("rd_data", ram_rd_data, rd_exp);
      end
    end
    if (!reset && eof !== 1'b0) begin
      if (eof_q.size() == 0) check("eof_unexpected", eof, 0);
      else begin
        eof_exp = eof_q.pop_front();
        check("eof_cycle", cyc, eof_exp.cyc);
        check("eof_frame_count", frame_count, eof_exp.fc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    reset_dut();

    // Nominal frame, then reads of first, second and last word
    send_frame(FW, 16'd0, 1'b1);
    idle(1);
    rd(10'd0); rd(10'd1); rd(10'd1023);
    idle(1);
    check_counters("nominal");

    // Hold in FULL, release, second frame
    idle(5);
    release_buf();
    send_frame(FW, 16'd100, 1'b1);
    idle(2);
    rd(10'd5);
    idle(1);
    check_counters("second");
    release_buf();

    // Drops, short frame, resync into a full frame, same-cycle release
    send_frame(3, 16'h5000, 1'b0);
    send_frame(11, 16'hA000, 1'b1);
    send_frame(FW, 16'hB000, 1'b1);
    release_buf();
    idle(1);
    rd(10'd0);
    idle(1);
    check_counters("resync");

    // sof on the last word restarts instead of completing; frame_done in FILL ignored
    send_frame(FW - 1, 16'h3000, 1'b1);
    drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, '0);
    for (int i = 1; i < FW; i++)
      drive(1'b1, 1'b0, 16'h7000 + 16'(i), (i % 97) == 0, 1'b0, '0);
    idle(1);
    rd(10'd0); rd(10'd1022); rd(10'd1023);
    idle(1);
    check_counters("last_sof");
    release_buf();

    // Random bubbles, reads during fill (incl. current write address), held valid in FULL
    drive(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0, '0);
    budget = 0;
    while (!m_full && budget < 10000) begin
      bit r;
      logic [AW-1:0] a;
      r = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 1) ? AW'(m_frame.size() % FW) : AW'($urandom);
      drive($urandom_range(0, 1) == 1, 1'b0, DW'($urandom),
            $urandom_range(0, 15) == 0, r, a);
      budget++;
    end
    check("random_frame_budget", budget < 10000, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) rd(AW'($urandom));
    idle(1);
    check_counters("random");
    release_buf();

    // Reset in the middle of a frame
    send_frame(500, 16'h2000, 1'b1);
    reset_dut();
    idle(2);
    for (int i = 0; i < FW; i++)
      drive(1'b1, i == 0, DW'($urandom), 1'b0, 1'b0, '0);
    idle(1);
    for (int i = 0; i < 20; i++) rd(AW'($urandom));
    idle(2);
    check_counters("after_reset");
    release_buf();
    idle(3);

    check("eof_missing", eof_q.size(), 0);
    check("rd_missing", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
